uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one `uart_tx` serializer among `NUM_REQ` byte producers. It sits between the requesters and the `uart_tx` input port (`i_din`/`i_valid`, watching `o_busy`). It accepts one byte at a time with a valid/ready handshake and launches it as a single-cycle `i_valid` pulse. It holds off further grants until the frame has finished. A missing busy response is flagged as an error.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_rr_pick.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 122 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Types and helpers shared by the UART transmit arbiter and its priority picker.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} tx_arb_state_t;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int grant_id_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority search: first set request at or above ptr, wrapping around.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = grant_id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [ID_W-1:0]    grant_id,
    output logic               any
);

    always_comb begin
        int              pos;
        logic [ID_W-1:0] idx;
        grant_onehot = '0;
        grant_id     = '0;
        any          = 1'b0;
        pos          = 0;
        idx          = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            idx = pos[ID_W-1:0];
            if (!any && req[idx]) begin
                any               = 1'b1;
                grant_onehot[idx] = 1'b1;
                grant_id          = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler feeding one uart_tx serializer from NUM_REQ byte producers,
// one frame at a time, with a watchdog on the serializer's busy response.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rstn,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_data,
    output logic [NUM_REQ-1:0]             o_req_ready,
    output logic [DATA_WIDTH-1:0]          o_tx_din,
    output logic                           o_tx_valid,
    input  logic                           i_tx_busy,
    output logic [grant_id_w(NUM_REQ)-1:0] o_grant_id,
    output logic                           o_active,
    output logic                           o_err_timeout
);

    localparam int ID_W  = grant_id_w(NUM_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    tx_arb_state_t                      state_q, state_d;
    logic [ID_W-1:0]                    rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0]              tx_din_q, tx_din_d;
    logic                               tx_valid_q, tx_valid_d;
    logic [ID_W-1:0]                    grant_id_q, grant_id_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;

    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_bytes;
    logic [NUM_REQ-1:0]                 pick_onehot;
    logic [ID_W-1:0]                    pick_id;
    logic                               pick_any;
    logic                               err_timeout;

    assign req_bytes = i_req_data;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req          (i_req_valid),
        .ptr          (rr_ptr_q),
        .grant_onehot (pick_onehot),
        .grant_id     (pick_id),
        .any          (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        tx_din_d    = tx_din_q;
        grant_id_d  = grant_id_q;
        cnt_d       = cnt_q;
        o_req_ready = '0;
        err_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                // Ready is gated by reset so no requester sees a phantom accept.
                if (i_rstn && !i_tx_busy && pick_any) begin
                    o_req_ready = pick_onehot;
                    tx_din_d    = req_bytes[pick_id];
                    grant_id_d  = pick_id;
                    rr_ptr_d    = (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;
                    state_d     = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (i_tx_busy) begin
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    // Serializer never answered: drop the byte rather than retry.
                    err_timeout = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!i_tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        tx_valid_d = (state_d == LAUNCH);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            tx_din_q   <= '0;
            tx_valid_q <= 1'b0;
            grant_id_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_din_q   <= tx_din_d;
            tx_valid_q <= tx_valid_d;
            grant_id_q <= grant_id_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_tx_din      = tx_din_q;
    assign o_tx_valid    = tx_valid_q;
    assign o_grant_id    = grant_id_q;
    assign o_active      = (state_q != IDLE);
    assign o_err_timeout = err_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a cycle-level transaction model and a busy-line stand-in for uart_tx.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int DW    = 8;
    localparam int NR    = 4;
    localparam int BT    = 4;
    localparam int FRAME = 10;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]   req_ready;
    logic [DW-1:0]   tx_din;
    logic            tx_valid;
    logic            tx_busy;
    logic [1:0]      grant_id;
    logic            active;
    logic            err_timeout;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int bcnt  = 0;
    logic tie0 = 1'b0;

    int          grants[$];
    logic [7:0]  bytes[$];
    int          launches[$];
    int          launch_cyc = -1;
    int          err_cyc = -1;
    int          err_cnt = 0;
    int          ready_cycles = 0;
    logic [NR-1:0] last_ready = '0;

    // Transaction model: m_phase = cycles since accept (-1 when idle).
    int         m_phase = -1;
    bit         m_seen = 1'b0;
    int         m_ptr = 0;
    logic [7:0] m_din = '0;
    int         m_gid = 0;

    always #20 clk = ~clk;

    uart_tx_arbiter #(
        .DATA_WIDTH   (DW),
        .NUM_REQ      (NR),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_req_valid   (req_valid),
        .i_req_data    (req_data),
        .o_req_ready   (req_ready),
        .o_tx_din      (tx_din),
        .o_tx_valid    (tx_valid),
        .i_tx_busy     (tx_busy),
        .o_grant_id    (grant_id),
        .o_active      (active),
        .o_err_timeout (err_timeout)
    );

    // Serializer stand-in: busy rises the cycle after it samples a launch, lasts FRAME cycles.
    assign tx_busy = (bcnt != 0);
    always @(posedge clk or negedge rstn) begin
        if (!rstn)                  bcnt <= 0;
        else if (tx_valid && !tie0) bcnt <= FRAME;
        else if (bcnt != 0)         bcnt <= bcnt - 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        int            w;
        logic [NR-1:0] e_ready;
        logic          e_err;
        logic [16:0]   exp_v;
        logic [16:0]   act_v;
        @(negedge clk);
        cyc++;
        if (!rstn) begin
            m_phase = -1; m_seen = 1'b0; m_ptr = 0; m_din = '0; m_gid = 0;
        end
        w = -1; e_ready = '0; e_err = 1'b0;
        if (m_phase < 0) begin
            if (rstn && !tx_busy) begin
                for (int i = 0; i < NR; i++) begin
                    int k;
                    k = (m_ptr + i) % NR;
                    if (w < 0 && req_valid[k]) w = k;
                end
            end
            if (w >= 0) e_ready[w] = 1'b1;
        end else if (m_phase >= 2 && !m_seen && !tx_busy && (m_phase - 1) == BT) begin
            e_err = 1'b1;
        end
        exp_v = {e_ready, 1'(m_phase == 1), m_din, 2'(m_gid), 1'(m_phase >= 0), e_err};
        act_v = {req_ready, tx_valid, tx_din, grant_id, active, err_timeout};
        check("outputs", 32'(act_v), 32'(exp_v));

        if (req_ready != '0) begin
            ready_cycles++;
            last_ready = req_ready;
            for (int i = 0; i < NR; i++) if (req_ready[i]) grants.push_back(i);
        end
        if (tx_valid) begin
            bytes.push_back(tx_din);
            launches.push_back(cyc);
            launch_cyc = cyc;
        end
        if (err_timeout) begin
            err_cyc = cyc;
            err_cnt++;
        end

        if (rstn) begin
            if (m_phase < 0) begin
                if (w >= 0) begin
                    m_phase = 1;
                    m_din   = req_data[w*DW +: DW];
                    m_gid   = w;
                    m_ptr   = (w + 1) % NR;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (!m_seen) begin
                if (tx_busy) begin
                    m_seen = 1'b1;
                    m_phase++;
                end else if (e_err) begin
                    m_phase = -1;
                end else begin
                    m_phase++;
                end
            end else if (!tx_busy) begin
                m_phase = -1;
                m_seen  = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_grants(input int n);
        int b = 0;
        while (grants.size() < n && b < 300) begin
            step(1);
            b++;
        end
        if (grants.size() < n) check("grant_wait", 32'(grants.size()), 32'(n));
    endtask

    task automatic wait_idle();
        int b = 0;
        while ((active || tx_busy) && b < 300) begin
            step(1);
            b++;
        end
        check("idle_reached", {30'd0, active, tx_busy}, 32'd0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset with every requester valid: ready must stay low.
        rstn = 1'b0;
        req_valid = '1;
        step(3);
        check("ready_in_reset", 32'(req_ready), 32'd0);
        req_valid = '0;
        step(1);
        rstn = 1'b1;
        step(2);

        // Single request from requester 2.
        grants.delete(); bytes.delete(); ready_cycles = 0;
        req_data[2*DW +: DW] = 8'hA6;
        req_valid = 4'b0100;
        wait_grants(1);
        req_valid = '0;
        wait_idle();
        check("single_ready", 32'(last_ready), 32'h4);
        check("single_ready_cycles", 32'(ready_cycles), 32'd1);
        check("single_grant", 32'(grants[0]), 32'd2);
        check("single_byte", 32'(bytes[0]), 32'hA6);

        // Reset during WAIT_DONE discards the frame in progress.
        req_data[2*DW +: DW] = 8'h5C;
        req_valid = 4'b0100;
        wait_grants(2);
        req_valid = '0;
        step(3);
        check("busy_before_reset", {30'd0, active, tx_busy}, 32'd3);
        rstn = 1'b0;
        #1;
        check("reset_outputs", 32'({req_ready, tx_valid, tx_din, grant_id, active, err_timeout}), 32'd0);
        step(1);
        rstn = 1'b1;

        // All four held valid after reset: pointer restarts at 0.
        grants.delete(); bytes.delete(); launches.delete();
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'b1111;
        wait_grants(5);
        req_valid = '0;
        wait_idle();
        check("rr_g0", 32'(grants[0]), 32'd0);
        check("rr_g1", 32'(grants[1]), 32'd1);
        check("rr_g2", 32'(grants[2]), 32'd2);
        check("rr_g3", 32'(grants[3]), 32'd3);
        check("rr_g4", 32'(grants[4]), 32'd0);
        check("rr_byte1", 32'(bytes[1]), 32'h11);
        check("rr_byte3", 32'(bytes[3]), 32'h13);
        check("rr_spacing", 32'(launches[4] - launches[3]), 32'(FRAME + 3));

        // Requester 1 always valid, requester 3 arrives mid-frame.
        grants.delete();
        req_data[1*DW +: DW] = 8'h21;
        req_data[3*DW +: DW] = 8'h33;
        req_valid = 4'b0010;
        wait_grants(1);
        step(3);
        req_valid = 4'b1010;
        wait_grants(2);
        req_valid = 4'b0010;
        wait_grants(3);
        req_valid = '0;
        wait_idle();
        check("fair_g0", 32'(grants[0]), 32'd1);
        check("fair_g1", 32'(grants[1]), 32'd3);
        check("fair_g2", 32'(grants[2]), 32'd1);

        // Serializer never raises busy: timeout then accept again.
        tie0 = 1'b1;
        grants.delete(); err_cnt = 0;
        req_valid = 4'b0001;
        wait_grants(1);
        req_valid = '0;
        wait_idle();
        check("to_count", 32'(err_cnt), 32'd1);
        check("to_delay", 32'(err_cyc - launch_cyc), 32'(BT));
        req_valid = 4'b0010;
        wait_grants(2);
        req_valid = '0;
        wait_idle();
        check("to_regrant", 32'(grants[1]), 32'd1);
        check("to_count2", 32'(err_cnt), 32'd2);
        tie0 = 1'b0;

        // Requester 0 withdraws while the serializer is busy.
        grants.delete();
        req_valid = 4'b1000;
        wait_grants(1);
        req_valid = '0;
        step(3);
        grants.delete(); bytes.delete();
        req_valid = 4'b0001;
        step(3);
        req_valid = '0;
        wait_idle();
        step(5);
        check("drop_no_grant", 32'(grants.size()), 32'd0);
        check("drop_no_frame", 32'(bytes.size()), 32'd0);

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
